instr_mem_latency: RTL and testbench

//  Parametrised instruction memory for the single-cycle CPU; successor to the hand-coded PC->INSTRUCTION case table.

---
 rtl/instr_mem_latency.sv | 79 +++++++
 tb/tb_instr_mem_latency.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/instr_mem_latency.sv
// instr_mem_latency: word-addressed instruction memory with programmable read latency and BUSY/VALID handshake
module instr_mem_latency #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int DEPTH = 256,
  parameter int LATENCY = 2,
  parameter logic [DATA_WIDTH-1:0] ILLEGAL_WORD = {DATA_WIDTH{1'b1}},
  localparam int IW = $clog2(DEPTH)
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic [ADDR_WIDTH-1:0] PC,
  input  logic                  READ,
  output logic [DATA_WIDTH-1:0] INSTRUCTION,
  output logic                  BUSY,
  output logic                  VALID,
  output logic                  ERROR,
  input  logic                  LOAD_EN,
  input  logic [IW-1:0]         LOAD_ADDR,
  input  logic [DATA_WIDTH-1:0] LOAD_DATA
);
  typedef enum logic {IDLE, FETCH} state_t;
  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] instr_q, instr_d;
  logic valid_q, valid_d, error_q, error_d;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic bad;
  // Word index compared at full PC width so stray high bits flag out of range
  assign bad = addr_q[1:0] != 2'b00 || {2'b00, addr_q[ADDR_WIDTH-1:2]} >= ADDR_WIDTH'(DEPTH);
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    addr_d = addr_q;
    instr_d = instr_q;
    error_d = error_q;
    valid_d = 1'b0;
    if (state_q == IDLE) begin
      if (READ) begin
        state_d = FETCH;
        addr_d = PC;
        cnt_d = 4'(LATENCY - 1);
      end
    end else if (cnt_q != 4'd0) begin
      cnt_d = cnt_q - 4'd1;
    end else begin
      state_d = IDLE;
      valid_d = 1'b1;
      error_d = bad;
      instr_d = bad ? ILLEGAL_WORD : mem[addr_q[IW+1:2]];
    end
  end
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= IDLE;
      cnt_q <= 4'd0;
      addr_q <= '0;
      instr_q <= '0;
      valid_q <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      addr_q <= addr_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      error_q <= error_d;
    end
  end
  // Storage is never reset; the completion read above sees the pre-write word
  always_ff @(posedge CLK) begin
    if (LOAD_EN) mem[LOAD_ADDR] <= LOAD_DATA;
  end
  assign INSTRUCTION = instr_q;
  assign BUSY = state_q == FETCH;
  assign VALID = valid_q;
  assign ERROR = error_q;
endmodule

// File: tb/tb_instr_mem_latency.sv
// tb_instr_mem_latency: three latency builds on shared stimulus, checked against a completion-time model
module tb_instr_mem_latency;
  localparam int LAT [3] = '{2, 1, 15};
  logic CLK = 1'b0, RESET = 1'b0, READ = 1'b0, LOAD_EN = 1'b0;
  logic [31:0] PC = '0, LOAD_DATA = '0;
  logic [2:0] LOAD_ADDR = '0;
  logic [31:0] ins_o [3];
  logic busy_o [3], val_o [3], err_o [3];
  int checks = 0, errors = 0;
  int cyc = 0;
  bit busy_m [3], val_m [3], err_m [3];
  int done_m [3];
  logic [31:0] a_m [3], ins_m [3];
  logic [31:0] mem_m [8];

  always #5 CLK = ~CLK;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    instr_mem_latency #(.DEPTH(8), .LATENCY(LAT[g])) u_dut (
      .CLK(CLK), .RESET(RESET), .PC(PC), .READ(READ),
      .INSTRUCTION(ins_o[g]), .BUSY(busy_o[g]), .VALID(val_o[g]), .ERROR(err_o[g]),
      .LOAD_EN(LOAD_EN), .LOAD_ADDR(LOAD_ADDR), .LOAD_DATA(LOAD_DATA)
    );
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      busy_m[i] = 0; val_m[i] = 0; err_m[i] = 0; ins_m[i] = '0;
    end
  endtask

  // A request accepted at edge k completes at edge k+LATENCY
  task automatic model_edge();
    cyc++;
    if (RESET) begin
      model_reset();
      return;
    end
    for (int i = 0; i < 3; i++) begin
      val_m[i] = 0;
      if (!busy_m[i]) begin
        if (READ) begin
          busy_m[i] = 1; done_m[i] = cyc + LAT[i]; a_m[i] = PC;
        end
      end else if (cyc == done_m[i]) begin
        busy_m[i] = 0; val_m[i] = 1;
        err_m[i] = a_m[i][1:0] != 0 || (a_m[i] >> 2) >= 8;
        ins_m[i] = err_m[i] ? 32'hFFFF_FFFF : mem_m[a_m[i][4:2]];
      end
    end
    if (LOAD_EN) mem_m[LOAD_ADDR] = LOAD_DATA;
  endtask

  task automatic check_all();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("busy_l%0d", LAT[i]), busy_o[i], busy_m[i]);
      chk($sformatf("valid_l%0d", LAT[i]), val_o[i], val_m[i]);
      chk($sformatf("error_l%0d", LAT[i]), err_o[i], err_m[i]);
      chk($sformatf("instr_l%0d", LAT[i]), ins_o[i], ins_m[i]);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic drain();
    for (int n = 0; n < 40 && (busy_m[0] || busy_m[1] || busy_m[2]); n++) step();
  endtask

  task automatic fetch(input logic [31:0] pc);
    PC = pc;
    READ = 1'b1;
    step();
    READ = 1'b0;
    PC = $urandom;
    drain();
  endtask

  function automatic logic [31:0] rand_pc();
    case ($urandom_range(0, 3))
      0, 1: return 32'($urandom_range(0, 7) * 4);
      2: return 32'($urandom_range(0, 40));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #1 RESET = 1'b1;
    #1 model_reset();
    check_all();
    step();
    RESET = 1'b0;
    for (int i = 0; i < 8; i++) begin
      LOAD_EN = 1'b1;
      LOAD_ADDR = 3'(i);
      LOAD_DATA = i == 0 ? 32'h0006000B : i == 1 ? 32'h00030006 : $urandom;
      step();
    end
    LOAD_EN = 1'b0;
    fetch(32'h0);
    chk("t1_instr", ins_o[0], 32'h0006000B);
    chk("t1_error", err_o[0], 0);
    fetch(32'h6);
    chk("t2_misaligned", {err_o[0], ins_o[0][30:0]}, {1'b1, 31'h7FFF_FFFF});
    fetch(32'h20);
    chk("t2_range", {err_o[0], ins_o[0][30:0]}, {1'b1, 31'h7FFF_FFFF});
    fetch(32'h8000_0000);
    chk("t2_highbit", err_o[0], 1);
    PC = 32'h0;
    READ = 1'b1;
    step();
    PC = 32'h4;
    step();
    step();
    chk("t3_latched", ins_o[0], 32'h0006000B);
    repeat (3) step();
    chk("t3_second", ins_o[0], 32'h00030006);
    READ = 1'b0;
    drain();
    PC = 32'h0;
    READ = 1'b1;
    step();
    READ = 1'b0;
    #3 RESET = 1'b1;
    #1 model_reset();
    check_all();
    step();
    RESET = 1'b0;
    step();
    fetch(32'h0);
    chk("t4_retained", ins_o[0], 32'h0006000B);
    PC = 32'h4;
    READ = 1'b1;
    step();
    READ = 1'b0;
    step();
    LOAD_EN = 1'b1;
    LOAD_ADDR = 3'd1;
    LOAD_DATA = 32'h00100603;
    step();
    LOAD_EN = 1'b0;
    chk("t5_old_word", ins_o[0], 32'h00030006);
    drain();
    fetch(32'h4);
    chk("t5_new_word", ins_o[0], 32'h00100603);
    repeat (1500) begin
      READ = $urandom_range(0, 3) != 0;
      PC = rand_pc();
      RESET = $urandom_range(0, 149) == 0;
      LOAD_EN = !RESET && $urandom_range(0, 3) == 0;
      LOAD_ADDR = 3'($urandom_range(0, 7));
      LOAD_DATA = $urandom;
      step();
    end
    RESET = 1'b0;
    READ = 1'b0;
    LOAD_EN = 1'b0;
    drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
